regfile_mp: RTL

Parametrised multi-port integer register file with write-to-read bypass, a per-register pending scoreboard, and a hardware reset sweep. It replaces the single-write, two-read register file in the decode stage of the in-order pipeline. Decode uses it to read operands and detect RAW hazards, issue marks destinations pending, and writeback ports clear them.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/regfile_mp.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the decode-stage register file.
// Decode and writeback use reg_addr_t for the standard 32-entry configuration.
package regfile_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;

   typedef enum logic {
      INIT,
      RUN
   } rf_state_e;

   typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one bit per register.
// Issue sets a bit, writeback clears it, and same-cycle writes mask the read view.
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int NR_RD = 2,
   parameter int NR_WR = 1,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       active,
   input  logic                       iss_en,
   input  logic [AW-1:0]              iss_addr,
   input  logic [NR_WR-1:0]           wr_en,
   input  logic [NR_WR-1:0][AW-1:0]   wr_addr,
   input  logic [NR_RD-1:0][AW-1:0]   rd_addr,
   output logic [NR_RD-1:0]           rd_pending
);

   logic [NREGS-1:0] pend_q;
   logic [NREGS-1:0] pend_d;

   // Clears are applied first so a same-edge issue to that register wins.
   always_comb begin
      pend_d = pend_q;
      if (active) begin
         for (int w = 0; w < NR_WR; w++) begin
            if (wr_en[w]) begin
               pend_d[wr_addr[w]] = 1'b0;
            end
         end
         if (iss_en && (iss_addr != '0)) begin
            pend_d[iss_addr] = 1'b1;
         end
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   always_comb begin
      rd_pending = '0;
      for (int j = 0; j < NR_RD; j++) begin
         if (active && (rd_addr[j] != '0)) begin
            rd_pending[j] = pend_q[rd_addr[j]];
            for (int w = 0; w < NR_WR; w++) begin
               if (wr_en[w] && (wr_addr[w] == rd_addr[j])) begin
                  rd_pending[j] = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, pending scoreboard
// and a post-reset sweep that zeroes every register before accepting traffic.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = 32,
   parameter int NR_RD = 2,
   parameter int NR_WR = 1,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          ready,
   input  logic [NR_RD-1:0][AW-1:0]      rd_addr,
   output logic [NR_RD-1:0][XLEN-1:0]    rd_data,
   output logic [NR_RD-1:0]              rd_pending,
   input  logic [NR_WR-1:0]              wr_en,
   input  logic [NR_WR-1:0][AW-1:0]      wr_addr,
   input  logic [NR_WR-1:0][XLEN-1:0]    wr_data,
   input  logic                          iss_en,
   input  logic [AW-1:0]                 iss_addr
);

   rf_state_e         state_q;
   logic [AW-1:0]     cnt_q;
   logic              ready_q;
   logic              active;
   logic [XLEN-1:0]   mem_q [NREGS];

   assign active = (state_q == RUN);
   assign ready  = ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               cnt_q <= cnt_q + AW'(1);
               if (cnt_q == AW'(NREGS - 1)) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= RUN;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Storage has no reset; the sweep zeroes it. Later ports overwrite earlier ones.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int w = 0; w < NR_WR; w++) begin
            if (wr_en[w] && (wr_addr[w] != '0)) begin
               mem_q[wr_addr[w]] <= wr_data[w];
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int j = 0; j < NR_RD; j++) begin
         if (active && (rd_addr[j] != '0)) begin
            rd_data[j] = mem_q[rd_addr[j]];
            for (int w = 0; w < NR_WR; w++) begin
               if (wr_en[w] && (wr_addr[w] == rd_addr[j])) begin
                  rd_data[j] = wr_data[w];
               end
            end
         end
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NR_RD (NR_RD),
      .NR_WR (NR_WR)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .active     (active),
      .iss_en     (iss_en),
      .iss_addr   (iss_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .rd_pending (rd_pending)
   );

endmodule
